// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and helpers for the I2C bus-clock generator
//
// Purpose: phase enumeration of one SCL period, default generator
// parameters, and the counter-to-phase decode used by i2c_clk_gen.
// Ports: none (package).

package i2c_pkg;

  // One SCL period is split into four equal quarters.
  //   Q0: SCL low,  data_clk low
  //   Q1: SCL low,  data_clk high
  //   Q2: SCL high, data_clk high
  //   Q3: SCL high, data_clk low
  typedef enum logic [1:0] {
    PH_Q0 = 2'd0,
    PH_Q1 = 2'd1,
    PH_Q2 = 2'd2,
    PH_Q3 = 2'd3
  } phase_e;

  // System clocks per quarter SCL period, and the longest tolerated
  // slave stretch in system clocks.
  localparam int unsigned DEFAULT_DIVIDER = 500;
  localparam int unsigned DEFAULT_TIMEOUT = 65535;

  // Map a phase count in [0, 4*d-1] to its quarter.
  function automatic phase_e phase_of(input int unsigned cnt, input int unsigned d);
    phase_e ph;
    if (cnt < d) begin
      ph = PH_Q0;
    end else if (cnt < 2 * d) begin
      ph = PH_Q1;
    end else if (cnt < 3 * d) begin
      ph = PH_Q2;
    end else begin
      ph = PH_Q3;
    end
    return ph;
  endfunction

  // SCL is released (high) in the second half of the period.
  function automatic logic scl_level(input phase_e ph);
    return (ph == PH_Q2) || (ph == PH_Q3);
  endfunction

  // data_clk is shifted one quarter ahead of SCL.
  function automatic logic data_level(input phase_e ph);
    return (ph == PH_Q1) || (ph == PH_Q2);
  endfunction

endpackage

// File: rtl/i2c_clk_gen_if.sv
// rtl/i2c_clk_gen_if.sv - control/status bundle between the clock generator and the bit FSM
//
// Purpose: groups the generator controls, the SCL pad readback and the
// generated clock levels/strobes/status.
// Modports:
//   master - the clock generator: consumes controls and pad readback,
//            drives clock levels, strobes and status.
//   slave  - the bit-level FSM / pad side: drives controls and readback,
//            consumes the generated clocks.
// Signals:
//   enable        1 = generate clock, 0 = idle
//   scl_ena       1 = master owns SCL, stretch detection active
//   scl_in        raw SCL pad readback (asynchronous)
//   clr_timeout   clears the sticky timeout flag
//   scl_clk       SCL drive level, 1 = release
//   data_clk      data-phase clock, one quarter ahead of scl_clk
//   data_clk_rise one-cycle pulse on data_clk 0->1
//   scl_rise      one-cycle pulse when Q2 is first released
//   stretching    counter is being held by a slave stretch
//   timeout       sticky: a stretch exceeded the limit

interface i2c_clk_gen_if;

  logic enable;
  logic scl_ena;
  logic scl_in;
  logic clr_timeout;

  logic scl_clk;
  logic data_clk;
  logic data_clk_rise;
  logic scl_rise;
  logic stretching;
  logic timeout;

  modport master (
    input  enable,
    input  scl_ena,
    input  scl_in,
    input  clr_timeout,
    output scl_clk,
    output data_clk,
    output data_clk_rise,
    output scl_rise,
    output stretching,
    output timeout
  );

  modport slave (
    output enable,
    output scl_ena,
    output scl_in,
    output clr_timeout,
    input  scl_clk,
    input  data_clk,
    input  data_clk_rise,
    input  scl_rise,
    input  stretching,
    input  timeout
  );

endinterface

// File: rtl/i2c_sync.sv
// rtl/i2c_sync.sv - two-flop synchroniser for an I2C pad readback
//
// Purpose: brings an asynchronous open-drain line into the clk domain.
// Resets to 1 because an idle I2C line is pulled high.
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   d    asynchronous pad level
//   q    synchronised level, two clocks behind d

module i2c_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;
  logic stable;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta   <= 1'b1;
      stable <= 1'b1;
    end else begin
      meta   <= d;
      stable <= meta;
    end
  end

  assign q = stable;

endmodule

// File: rtl/i2c_clk_gen.sv
// rtl/i2c_clk_gen.sv - I2C bus-clock generator with slave stretch and stretch timeout
//
// Purpose: divides clk into a four-quarter SCL period of 4*DIVIDER clocks,
// produces the SCL drive level and a quarter-leading data_clk, holds the
// period at the start of Q2 while a slave stretches SCL low, and forces
// release (with a sticky timeout flag) after TIMEOUT stretched clocks.
// Ports:
//   clk  system clock, all logic on posedge
//   rst  synchronous active-high reset
//   bus  i2c_clk_gen_if.master: controls in, clock levels/strobes/status out
// Parameters:
//   DIVIDER  clocks per quarter SCL period (>= 2)
//   TIMEOUT  longest stretch in clocks before forced release (>= 1)

module i2c_clk_gen
  import i2c_pkg::*;
#(
  parameter int unsigned DIVIDER = DEFAULT_DIVIDER,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input logic           clk,
  input logic           rst,
  i2c_clk_gen_if.master bus
);

  localparam int unsigned CBITS = $clog2(4 * DIVIDER);
  localparam int unsigned TBITS = $clog2(TIMEOUT + 1);

  localparam logic [CBITS-1:0] CNT_D    = CBITS'(DIVIDER);
  localparam logic [CBITS-1:0] CNT_2D   = CBITS'(2 * DIVIDER);
  localparam logic [CBITS-1:0] CNT_LAST = CBITS'(4 * DIVIDER - 1);
  localparam logic [TBITS-1:0] STR_MAX  = TBITS'(TIMEOUT);

  logic [CBITS-1:0] cnt;
  logic [CBITS-1:0] cnt_next;
  logic [TBITS-1:0] stretch_cnt;
  logic [TBITS-1:0] stretch_next;

  logic   scl_sync;
  logic   at_q2_start;
  logic   stretch_req;
  logic   stretch_limit;
  logic   hold;
  logic   timeout_evt;
  phase_e phase_next;

  i2c_sync u_scl_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.scl_in),
    .q   (scl_sync)
  );

  // Stretch is only ever considered at the first count of Q2: that is the
  // point where we have just released SCL and a slave may be holding it low.
  always_comb begin
    at_q2_start   = (cnt == CNT_2D);
    stretch_req   = bus.enable && at_q2_start && bus.scl_ena && !scl_sync;
    stretch_limit = (stretch_cnt == STR_MAX);
    hold          = stretch_req && !stretch_limit;
    timeout_evt   = stretch_req && stretch_limit;
  end

  // Next phase count.
  always_comb begin
    cnt_next = cnt;
    if (!bus.enable) begin
      cnt_next = '0;
    end else if (hold) begin
      cnt_next = cnt;
    end else if (cnt == CNT_LAST) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt + 1'b1;
    end
  end

  // Stretch length counter: only live while parked at the start of Q2.
  // It never exceeds STR_MAX because hold is false once the limit is hit.
  always_comb begin
    stretch_next = '0;
    if (bus.enable && at_q2_start) begin
      if (hold) begin
        stretch_next = stretch_cnt + 1'b1;
      end else begin
        stretch_next = stretch_cnt;
      end
    end
  end

  // Outputs are registered from the next count so they line up with cnt
  // in the same cycle and have no combinational path from any input.
  always_comb begin
    phase_next = phase_of(32'(cnt_next), DIVIDER);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt               <= '0;
      stretch_cnt       <= '0;
      bus.scl_clk       <= 1'b1;
      bus.data_clk      <= 1'b0;
      bus.data_clk_rise <= 1'b0;
      bus.scl_rise      <= 1'b0;
      bus.stretching    <= 1'b0;
      bus.timeout       <= 1'b0;
    end else begin
      cnt         <= cnt_next;
      stretch_cnt <= stretch_next;

      if (bus.enable) begin
        bus.scl_clk       <= scl_level(phase_next);
        bus.data_clk      <= data_level(phase_next);
        // cnt never holds at D, so reaching D is always a fresh rise.
        bus.data_clk_rise <= (cnt_next == CNT_D);
        // Fires as cnt leaves 2D, whether released by the slave, by
        // scl_ena being low, or by the timeout.
        bus.scl_rise      <= at_q2_start && !hold;
        bus.stretching    <= hold;
      end else begin
        bus.scl_clk       <= 1'b1;
        bus.data_clk      <= 1'b0;
        bus.data_clk_rise <= 1'b0;
        bus.scl_rise      <= 1'b0;
        bus.stretching    <= 1'b0;
      end

      // A new timeout in the same cycle as a clear leaves the flag set.
      if (timeout_evt) begin
        bus.timeout <= 1'b1;
      end else if (bus.clr_timeout) begin
        bus.timeout <= 1'b0;
      end
    end
  end

endmodule

// File: doc/i2c_clk_gen.md
Name: i2c_clk_gen

Overview:
Parametrised I2C bus-clock generator with slave clock-stretch support and stretch timeout. It replaces the fixed divide-by-500 stretch block in the I2C master. It produces the SCL drive level and a quarter-shifted data_clk for the bit-level FSM. It adds an enable/idle mode, a 2-flop-synchronised SCL readback, a timeout flag and phase strobes.

Parameters:
DIVIDER, 500, system clocks per quarter SCL period; legal range is 2 or more; SCL period = 4*DIVIDER.
TIMEOUT, 65535, maximum stretch length in clocks before forced release; legal range is 1 or more.
CBITS, $clog2(4*DIVIDER), localparam, phase counter width.
TBITS, $clog2(TIMEOUT+1), localparam, stretch counter width.

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous, active-high reset
enable  input  1  1 = generate clock; 0 = idle
scl_ena  input  1  1 = master currently owns SCL; stretch detection enabled
scl_in  input  1  raw SCL pad readback, asynchronous
clr_timeout  input  1  clears sticky timeout flag
scl_clk  output  1  SCL drive level; 1 = release/high
data_clk  output  1  data-phase clock, leads scl_clk by one quarter
data_clk_rise  output  1  one-cycle pulse when data_clk goes 0->1
scl_rise  output  1  one-cycle pulse when phase Q2 is first released
stretching  output  1  counter currently held by slave stretch
timeout  output  1  sticky: a stretch exceeded TIMEOUT

Behaviour:
- Reset is synchronous and active-high. Reset values: cnt=0, stretch count=0, both sync flops=1, stretching=0, timeout=0, all strobes=0.
- All outputs are registered. There is no combinational path from any input to any output.
- Phase is derived from cnt (0..4*DIVIDER-1):
  - Q0 = [0, D-1]: scl=0, data_clk=0.
  - Q1 = [D, 2D-1]: scl=0, data_clk=1.
  - Q2 = [2D, 3D-1]: scl=1, data_clk=1.
  - Q3 = [3D, 4D-1]: scl=1, data_clk=0.
- Counter:
  - If enable=1 and not held: cnt increments.
  - cnt wraps from 4D-1 to 0.
- Idle: while enable=0, the next cycle gives cnt=0, scl_clk=1, data_clk=0, stretching=0, strobes=0, and the stretch count is cleared. On enable 0->1, counting starts from Q0; the first cycle after enable shows scl_clk=0.
- Stretch check happens only at cnt==2D. Hold cnt at 2D while all of the following are true:
  - scl_ena=1
  - synchronised scl_in=0
  - the stretch count has not reached TIMEOUT
- While holding:
  - stretching=1.
  - The stretch count increments.
  - scl_clk=1 (released); data_clk=1.
- Release:
  - When synchronised scl_in=1, or scl_ena=0, cnt advances to 2D+1 on the next edge and stretching=0.
  - The stretch count clears on any cycle where cnt is not 2D.
- Timeout:
  - When the stretch count reaches TIMEOUT, timeout is set and cnt advances regardless of scl_in.
  - timeout stays set until rst, or until clr_timeout=1. If clr_timeout and a new timeout event occur in the same cycle, set wins.
- Strobes:
  - data_clk_rise is high for exactly the one cycle where cnt==D.
  - scl_rise is high for the one cycle where cnt first leaves 2D (immediately if there is no stretch).
- scl_ena=0 during Q2 entry means no stretch is possible, which matches master-released SCL during ACK/read.
- A reset asserted mid-stretch or mid-period overrides everything in that cycle.
- Synchroniser latency: a scl_in change is visible to the stretch logic 2 cycles later. Stretch termination therefore lags the pad by 2 to 3 cycles.

Decomposition:
- Package i2c_pkg holds:
  - typedef enum of the 2-bit phase {PH_Q0, PH_Q1, PH_Q2, PH_Q3};
  - the default DIVIDER and TIMEOUT constants;
  - the helper function phase_of(cnt, D).
- Sub-module i2c_sync: 2-flop synchroniser, reset value 1, reused later for the SDA readback.

Test Plan:
1. DIVIDER=4, enable=1, scl_in tied 1, run 48 cycles -> period 16; scl_clk low 8 and high 8; data_clk high during cnt 4..11; data_clk_rise every 16 cycles; timeout=0.
2. DIVIDER=4, scl_ena=1, scl_in=0 held 20 cycles from cnt=6 -> cnt holds at 8; stretching=1; scl_rise occurs 2 to 3 cycles after scl_in returns to 1; period is extended by the stretch length.
3. Same as scenario 2 with scl_ena=0 -> no hold; stretching never asserts; period stays 16.
4. DIVIDER=4, TIMEOUT=10, scl_in stuck 0 -> stretching for exactly 10 cycles, then timeout=1 and cnt=9; the flag persists across periods; clr_timeout pulse clears it to 0 on the next cycle.
5. enable dropped mid-Q1 -> next cycle gives scl_clk=1, data_clk=0, cnt=0; on re-enable, scl_clk=0 and data_clk_rise occurs at cycle 4.
6. rst pulsed during an active stretch -> all outputs at their reset values on the next edge; counting restarts from 0.
